// File: rtl/gen_synchronizer_if.sv
// Bundle between the generation sequencer and its surroundings: worker done
// levels, renderer blanking, double-buffer ready, run/step control in one
// direction; start/swap pulses, generation count and status flags in the other.
//
// Handshake (the only one on this bundle): buf_swap_out is a one-cycle request
// pulse; the sequencer then waits any number of cycles for buf_ready_in, which
// is only honoured while the sequencer is waiting for it (WAIT_BUF). A ready
// level seen in any other state, including the swap cycle itself, is ignored.
// The master modport is the environment; the slave modport is the sequencer.
interface gen_synchronizer_if #(
    parameter int NUM_WORKERS = 4,
    parameter int GEN_W       = 16,
    parameter int FPG_W       = 4
);
    logic [NUM_WORKERS-1:0] logic_done_in;
    logic                   render_done_in;
    logic                   buf_ready_in;
    logic                   run_in;
    logic                   step_in;
    logic [FPG_W-1:0]       frames_per_gen_in;
    logic                   logic_start_out;
    logic                   buf_swap_out;
    logic [GEN_W-1:0]       gen_count_out;
    logic                   busy_out;
    logic                   timeout_out;

    modport master (
        output logic_done_in, render_done_in, buf_ready_in, run_in, step_in,
               frames_per_gen_in,
        input  logic_start_out, buf_swap_out, gen_count_out, busy_out, timeout_out
    );

    modport slave (
        input  logic_done_in, render_done_in, buf_ready_in, run_in, step_in,
               frames_per_gen_in,
        output logic_start_out, buf_swap_out, gen_count_out, busy_out, timeout_out
    );
endinterface

// File: rtl/gen_synchronizer.sv
// Generation sequencer: waits for all workers done, renderer blanking and the
// frame quota, then pulses a buffer swap, waits for buffer ready and pulses the
// next generation start. Run/pause/single-step control, generation counter and
// busy flag. Optional WAIT_BUF watchdog enabled by defining GEN_SYNC_WATCHDOG_EN;
// without it timeout_out is tied to 0. dbg_state_out exposes the FSM state
// (0 IDLE, 1 SWAP, 2 WAIT_BUF, 3 START, 4 WAIT_RENDER).
module gen_synchronizer #(
    parameter int NUM_WORKERS    = 4,
    parameter int GEN_W          = 16,
    parameter int FPG_W          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk_in,
    input  logic                rst_in,
    gen_synchronizer_if.slave   bus,
    output logic [2:0]          dbg_state_out
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SWAP        = 3'd1,
        WAIT_BUF    = 3'd2,
        START       = 3'd3,
        WAIT_RENDER = 3'd4
    } state_t;

    if (NUM_WORKERS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("gen_synchronizer: NUM_WORKERS and TIMEOUT_CYCLES must be >= 1");
    end

    state_t                 state_q, state_d;
    logic [NUM_WORKERS-1:0] done_prev_q, done_prev_d;
    logic [NUM_WORKERS-1:0] done_latch_q, done_latch_d;
    logic                   render_prev_q, render_prev_d;
    logic [FPG_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic                   step_pending_q, step_pending_d;
    logic                   buf_swap_q, buf_swap_d;
    logic                   logic_start_q, logic_start_d;
    logic                   busy_q, busy_d;
    logic [GEN_W-1:0]       gen_count_q, gen_count_d;

    logic [FPG_W-1:0]       fpg_eff;
    logic                   quota_met;
    logic                   step_ok;
    logic                   go;

    // Qualifiers for leaving IDLE; a zero quota behaves like one frame.
    always_comb begin
        fpg_eff   = (bus.frames_per_gen_in == '0) ? FPG_W'(1) : bus.frames_per_gen_in;
        quota_met = (frame_cnt_q >= fpg_eff);
        step_ok   = bus.run_in | step_pending_q | (bus.step_in & ~bus.run_in);
        go        = (&done_latch_q) & bus.render_done_in & quota_met & step_ok;
    end

    // Next-state, edge latches, frame count, step request and registered outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (go) state_d = SWAP;
            SWAP:        state_d = WAIT_BUF;
            WAIT_BUF:    if (bus.buf_ready_in) state_d = START;
            START:       state_d = WAIT_RENDER;
            WAIT_RENDER: if (!bus.render_done_in) state_d = IDLE;
            default:     state_d = IDLE;
        endcase

        done_prev_d   = bus.logic_done_in;
        render_prev_d = bus.render_done_in;

        // Latches and frame count restart in the start cycle; edges in it are dropped.
        if (state_q == START) begin
            done_latch_d = '0;
            frame_cnt_d  = '0;
        end else begin
            done_latch_d = done_latch_q | (bus.logic_done_in & ~done_prev_q);
            frame_cnt_d  = frame_cnt_q;
            if (bus.render_done_in && !render_prev_q && (frame_cnt_q != '1)) begin
                frame_cnt_d = frame_cnt_q + FPG_W'(1);
            end
        end

        // A step consumed by the swap clears the request; repeats collapse.
        if (state_q == IDLE && go) begin
            step_pending_d = 1'b0;
        end else if (bus.step_in && !bus.run_in) begin
            step_pending_d = 1'b1;
        end else begin
            step_pending_d = step_pending_q;
        end

        buf_swap_d    = (state_d == SWAP);
        logic_start_d = (state_d == START);
        busy_d        = (state_d != IDLE);
        gen_count_d   = (state_d == START) ? gen_count_q + GEN_W'(1) : gen_count_q;
    end

    // All sequencer state, reset synchronously.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            done_prev_q    <= '0;
            done_latch_q   <= '0;
            render_prev_q  <= 1'b0;
            frame_cnt_q    <= '0;
            step_pending_q <= 1'b0;
            buf_swap_q     <= 1'b0;
            logic_start_q  <= 1'b0;
            busy_q         <= 1'b0;
            gen_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            done_prev_q    <= done_prev_d;
            done_latch_q   <= done_latch_d;
            render_prev_q  <= render_prev_d;
            frame_cnt_q    <= frame_cnt_d;
            step_pending_q <= step_pending_d;
            buf_swap_q     <= buf_swap_d;
            logic_start_q  <= logic_start_d;
            busy_q         <= busy_d;
            gen_count_q    <= gen_count_d;
        end
    end

`ifdef GEN_SYNC_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    // Count cycles spent in WAIT_BUF; the flag is sticky, the FSM keeps waiting.
    always_comb begin
        wd_cnt_d = '0;
        if (state_q == WAIT_BUF) begin
            wd_cnt_d = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES)) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
        end
        timeout_d = timeout_q | (wd_cnt_d == WD_W'(TIMEOUT_CYCLES));
    end

    // Watchdog registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_out = timeout_q;
`else
    assign bus.timeout_out = 1'b0;
`endif

    assign bus.buf_swap_out    = buf_swap_q;
    assign bus.logic_start_out = logic_start_q;
    assign bus.busy_out        = busy_q;
    assign bus.gen_count_out   = gen_count_q;
    assign dbg_state_out       = state_q;

endmodule

// File: tb/tb_gen_synchronizer.sv
// Bench for gen_synchronizer (GEN_W=4 so the counter wrap is cheap to reach).
`timescale 1ns/1ps
module tb_gen_synchronizer;
  localparam int NW = 4;
  localparam int GW = 4;
  localparam int FW = 4;
  localparam int TO = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  gen_synchronizer_if #(.NUM_WORKERS(NW), .GEN_W(GW), .FPG_W(FW)) bus();

  gen_synchronizer #(.NUM_WORKERS(NW), .GEN_W(GW), .FPG_W(FW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .bus          (bus),
    .dbg_state_out(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [GW-1:0] exp_q[$];
  logic [GW-1:0] exp_gen = '0;
  int cyc = 0;
  int swap_cnt = 0;
  int start_cnt = 0;
  int last_ready_cyc = -100;
  int buf_delay = 0;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [GW-1:0] e;
    cyc++;
    if (bus.buf_ready_in) last_ready_cyc = cyc;
    if (bus.buf_swap_out) swap_cnt++;
    if (bus.logic_start_out) begin
      start_cnt++;
      checks++;
      if (bus.buf_swap_out !== 1'b0) begin
        errors++;
        $display("FAIL pulse_overlap: buf_swap=%b with logic_start, required 0", bus.buf_swap_out);
      end
      checks++;
      if ((cyc - last_ready_cyc) !== 1) begin
        errors++;
        $display("FAIL start_latency: start %0d cycles after buf_ready, required 1", cyc - last_ready_cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: gen_count=%0d, no start expected", bus.gen_count_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.gen_count_out !== e) begin
          errors++;
          $display("FAIL gen_count: got %0d required %0d", bus.gen_count_out, e);
        end
      end
    end
  end

  // Buffer model: answers each swap with a one-cycle ready after buf_delay cycles.
  initial begin
    bus.buf_ready_in = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.buf_swap_out) begin
        repeat (buf_delay + 1) @(posedge clk);
        #1 bus.buf_ready_in = 1'b1;
        @(posedge clk);
        #1 bus.buf_ready_in = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rearm(input logic [NW-1:0] mask);
    bus.logic_done_in = '0;
    tick(1);
    bus.logic_done_in = mask;
    tick(1);
  endtask

  task automatic push_gen();
    exp_gen = exp_gen + 1'b1;
    exp_q.push_back(exp_gen);
  endtask

  task automatic wait_start(input int budget, output bit seen);
    int s0;
    int n;
    s0 = start_cnt;
    n = 0;
    while (start_cnt == s0 && n < budget) begin
      tick(1);
      n++;
    end
    seen = (start_cnt != s0);
  endtask

  task automatic wait_swap(input int budget, output bit seen);
    int n;
    n = 0;
    while (bus.buf_swap_out !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    seen = (bus.buf_swap_out === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({bus.logic_start_out, bus.buf_swap_out, bus.busy_out, bus.timeout_out} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: start/swap/busy/timeout=%b required 0000",
               {bus.logic_start_out, bus.buf_swap_out, bus.busy_out, bus.timeout_out});
    end
    checks++;
    if (bus.gen_count_out !== '0) begin
      errors++;
      $display("FAIL reset_gen_count: got %0d required 0", bus.gen_count_out);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    bit seen;
    int s0;
    bus.run_in = 1'b1;
    bus.frames_per_gen_in = 4'd1;
    bus.logic_done_in[0] = 1'b1; tick(3);
    bus.logic_done_in[2] = 1'b1; tick(2);
    bus.logic_done_in[1] = 1'b1; tick(4);
    bus.logic_done_in[3] = 1'b1; tick(3);
    checks++;
    if (swap_cnt !== 0 || bus.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_render: swaps=%0d busy=%b required 0/0", swap_cnt, bus.busy_out);
    end
    s0 = swap_cnt;
    push_gen();
    bus.render_done_in = 1'b1;
    wait_start(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL basic_start: no logic_start within 20 cycles");
    end
    checks++;
    if (swap_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL basic_swap_count: got %0d swaps required 1", swap_cnt - s0);
    end
    // Workers 0..2 finish again during the same blanking; worker 3 stays low.
    rearm(4'b0111);
    tick(10);
    checks++;
    if (swap_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL basic_same_blanking: got %0d swaps required 1", swap_cnt - s0);
    end
    bus.render_done_in = 1'b0;
    tick(3);
    checks++;
    if (bus.busy_out !== 1'b0 || bus.gen_count_out !== 4'd1) begin
      errors++;
      $display("FAIL basic_idle: busy=%b gen_count=%0d required 0/1", bus.busy_out, bus.gen_count_out);
    end
  endtask

  task automatic test_missing_worker();
    bit seen;
    int s0;
    s0 = swap_cnt;
    for (int i = 0; i < 100; i++) begin
      bus.render_done_in = 1'b1; tick(5);
      bus.render_done_in = 1'b0; tick(5);
    end
    checks++;
    if (swap_cnt !== s0) begin
      errors++;
      $display("FAIL missing_worker: got %0d swaps required 0", swap_cnt - s0);
    end
    bus.logic_done_in[3] = 1'b1;
    tick(2);
    push_gen();
    bus.render_done_in = 1'b1;
    wait_start(20, seen);
    checks++;
    if (!seen || swap_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL worker3_late: seen=%b swaps=%0d required 1/1", seen, swap_cnt - s0);
    end
    bus.render_done_in = 1'b0;
    tick(3);
  endtask

  task automatic test_quota();
    bit seen;
    int s0;
    bus.frames_per_gen_in = 4'd3;
    rearm(4'b1111);
    s0 = start_cnt;
    for (int p = 1; p <= 2; p++) begin
      bus.render_done_in = 1'b1; tick(4);
      bus.render_done_in = 1'b0; tick(4);
      checks++;
      if (start_cnt !== s0) begin
        errors++;
        $display("FAIL quota3_early: start after %0d frames, required 3", p);
      end
    end
    push_gen();
    bus.render_done_in = 1'b1;
    wait_start(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL quota3_third: no logic_start after third frame");
    end
    bus.render_done_in = 1'b0;
    tick(4);
    bus.frames_per_gen_in = 4'd0;
    rearm(4'b1111);
    push_gen();
    bus.render_done_in = 1'b1;
    wait_start(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL quota0_as_1: no logic_start after one frame with fpg=0");
    end
    bus.render_done_in = 1'b0;
    tick(3);
  endtask

  task automatic test_step();
    bit seen;
    int s0;
    bus.run_in = 1'b0;
    bus.frames_per_gen_in = 4'd1;
    rearm(4'b1111);
    bus.render_done_in = 1'b1;
    tick(20);
    s0 = start_cnt;
    checks++;
    if (bus.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL paused_busy: busy=%b required 0", bus.busy_out);
    end
    push_gen();
    bus.step_in = 1'b1; tick(1); bus.step_in = 1'b0;
    wait_start(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL step_single: no logic_start after step");
    end
    bus.render_done_in = 1'b0; tick(3);
    rearm(4'b1111);
    bus.render_done_in = 1'b1; tick(20);
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL step_consumed: got %0d starts required 1", start_cnt - s0);
    end
    bus.render_done_in = 1'b0; tick(2);
    bus.step_in = 1'b1; tick(1); bus.step_in = 1'b0; tick(2);
    bus.step_in = 1'b1; tick(1); bus.step_in = 1'b0; tick(2);
    push_gen();
    bus.render_done_in = 1'b1;
    wait_start(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL step_pending: no logic_start for pending step");
    end
    bus.render_done_in = 1'b0; tick(2);
    rearm(4'b1111);
    bus.render_done_in = 1'b1; tick(20);
    checks++;
    if (start_cnt - s0 !== 2) begin
      errors++;
      $display("FAIL step_collapse: got %0d starts required 2", start_cnt - s0);
    end
    bus.render_done_in = 1'b0; tick(2);
  endtask

  task automatic test_watchdog();
    bit seen;
    logic exp_to;
`ifdef GEN_SYNC_WATCHDOG_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    buf_delay = 5000;
    bus.run_in = 1'b1;
    push_gen();
    bus.render_done_in = 1'b1;
    wait_swap(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wd_swap: no buf_swap within 20 cycles");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "sequencer stalled");
    end
    tick(1);
    tick(TO - 1);
    checks++;
    if (bus.timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL wd_early: timeout=%b at WAIT_BUF+%0d required 0", bus.timeout_out, TO - 1);
    end
    tick(1);
    checks++;
    if (bus.timeout_out !== exp_to || dbg_state !== 3'd2 || bus.busy_out !== 1'b1) begin
      errors++;
      $display("FAIL wd_fire: timeout=%b state=%0d busy=%b required %b/2/1",
               bus.timeout_out, dbg_state, bus.busy_out, exp_to);
    end
    wait_start(1200, seen);
    checks++;
    if (!seen || bus.timeout_out !== exp_to) begin
      errors++;
      $display("FAIL wd_late_ready: seen=%b timeout=%b required 1/%b", seen, bus.timeout_out, exp_to);
    end
    bus.render_done_in = 1'b0;
    buf_delay = 0;
    tick(3);
  endtask

  task automatic test_reset_mid();
    bit seen;
    int s0;
    int t0;
    buf_delay = 20;
    rearm(4'b1111);
    bus.render_done_in = 1'b1;
    wait_swap(20, seen);
    tick(2);
    rst = 1'b1;
    bus.logic_done_in = '0;
    bus.render_done_in = 1'b0;
    tick(1);
    checks++;
    if ({bus.logic_start_out, bus.buf_swap_out, bus.busy_out, bus.timeout_out} !== 4'b0 ||
        bus.gen_count_out !== '0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b gen_count=%0d state=%0d required 0000/0/0",
               {bus.logic_start_out, bus.buf_swap_out, bus.busy_out, bus.timeout_out},
               bus.gen_count_out, dbg_state);
    end
    rst = 1'b0;
    exp_gen = '0;
    s0 = swap_cnt;
    t0 = start_cnt;
    tick(40);
    checks++;
    if (swap_cnt !== s0 || start_cnt !== t0) begin
      errors++;
      $display("FAIL reset_abort: swaps=%0d starts=%0d after reset required 0/0",
               swap_cnt - s0, start_cnt - t0);
    end
    // Levels already high while in reset must still start a generation.
    buf_delay = 0;
    bus.logic_done_in = '1;
    bus.render_done_in = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    push_gen();
    wait_start(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_held_high: no logic_start after reset with held-high inputs");
    end
    for (int k = 0; k < 15; k++) begin
      bus.render_done_in = 1'b0;
      tick(1);
      rearm(4'b1111);
      push_gen();
      bus.render_done_in = 1'b1;
      wait_start(20, seen);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL wrap_gen: no logic_start in wrap loop step %0d", k);
      end
    end
    tick(1);
    checks++;
    if (bus.gen_count_out !== 4'd0) begin
      errors++;
      $display("FAIL gen_wrap: got %0d required 0", bus.gen_count_out);
    end
    bus.render_done_in = 1'b0;
    tick(3);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    bus.logic_done_in = '0;
    bus.render_done_in = 1'b0;
    bus.run_in = 1'b0;
    bus.step_in = 1'b0;
    bus.frames_per_gen_in = '0;
    test_reset();
    test_basic();
    test_missing_worker();
    test_quota();
    test_step();
    test_watchdog();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected starts never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
